jpeg_block_deserializer: RTL

//  AXI-Stream receiver at the output end of the JPEG pipeline. Accepts one signed DATA_WIDTH-bit

---
 rtl/jpeg_pkg.sv | 22 ++
 rtl/jpeg_zigzag_rom.sv | 11 +
 rtl/jpeg_block_deserializer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/jpeg_pkg.sv
// rtl/jpeg_pkg.sv - shared constants, zigzag table and state types for the JPEG block deserializer
package jpeg_pkg;

  localparam int DATA_WIDTH  = 15;
  localparam int PIXEL_COUNT = 64;

  // Entry k is the raster address of the k-th coefficient in zigzag order.
  localparam logic [5:0] ZIGZAG_TO_RASTER [0:63] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} bank_state_t;
  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} rd_state_t;

endpackage

// File: rtl/jpeg_zigzag_rom.sv
// rtl/jpeg_zigzag_rom.sv - combinational zigzag index to raster address lookup
module jpeg_zigzag_rom
  import jpeg_pkg::*;
(
  input  logic [5:0] zz_idx,
  output logic [5:0] raster_addr
);

  assign raster_addr = ZIGZAG_TO_RASTER[zz_idx];

endmodule

// File: rtl/jpeg_block_deserializer.sv
// rtl/jpeg_block_deserializer.sv - ping-pong 8x8 zigzag-to-raster reorder buffer, AXI-Stream in/out
// Optional framing check: JPEG_DESER_TLAST_CHECK_EN
module jpeg_block_deserializer
  import jpeg_pkg::*;
#(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int DATA_WIDTH             = jpeg_pkg::DATA_WIDTH,
  parameter int DATA_DEPTH             = 8,
  parameter int PIXEL_COUNT            = DATA_DEPTH * DATA_DEPTH
) (
  input  logic                                axis_aclk,
  input  logic                                axis_rst,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                                s00_axis_tlast,
  input  logic                                s00_axis_tvalid,
  output logic                                s00_axis_tready,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                                m00_axis_tlast,
  output logic                                m00_axis_tvalid,
  input  logic                                m00_axis_tready,
  output logic                                err_tlast
);

  localparam logic [5:0] LAST_IDX = 6'(PIXEL_COUNT - 1);

  logic [DATA_WIDTH-1:0] mem [0:1][0:63];
  bank_state_t           bank_st [0:1];
  bank_state_t           bank_nxt [0:1];
  rd_state_t             rd_state;
  logic                  wr_bank, rd_bank, rd_bank_nxt;
  logic [5:0]            wr_idx, rd_idx, rd_idx_nxt, wr_addr;
  logic                  wr_fire, wr_close, rd_fire, rd_close;
  logic [DATA_WIDTH-1:0] rd_coef;
  logic                  unused_in;

  jpeg_zigzag_rom u_zigzag_rom (
    .zz_idx      (wr_idx),
    .raster_addr (wr_addr)
  );

  assign s00_axis_tready = (bank_st[wr_bank] == EMPTY);
  assign m00_axis_tvalid = (rd_state == STREAM);
  assign m00_axis_tstrb  = '1;
  assign wr_fire  = s00_axis_tvalid & s00_axis_tready;
  assign rd_fire  = m00_axis_tvalid & m00_axis_tready;
  assign rd_close = rd_fire & (rd_idx == LAST_IDX);

`ifdef JPEG_DESER_TLAST_CHECK_EN
  logic [63:0] wr_mask [0:1];

  assign wr_close  = wr_fire & (s00_axis_tlast | (wr_idx == LAST_IDX));
  // Positions skipped by an early tlast were never written this block and read as zero.
  assign rd_coef   = wr_mask[rd_bank][rd_idx] ? mem[rd_bank][rd_idx] : '0;
  assign unused_in = ^{s00_axis_tstrb, s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:DATA_WIDTH]};

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      wr_mask[0] <= '0;
      wr_mask[1] <= '0;
      err_tlast  <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_mask[wr_bank][wr_addr] <= 1'b1;
        if (s00_axis_tlast != (wr_idx == LAST_IDX))
          err_tlast <= 1'b1;
      end
      if (rd_close)
        wr_mask[rd_bank] <= '0;
    end
  end
`else
  assign wr_close  = wr_fire & (wr_idx == LAST_IDX);
  assign rd_coef   = mem[rd_bank][rd_idx];
  assign err_tlast = 1'b0;
  assign unused_in = ^{s00_axis_tstrb, s00_axis_tlast,
                       s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:DATA_WIDTH]};
`endif

  assign m00_axis_tdata = {{(C_M00_AXIS_TDATA_WIDTH - DATA_WIDTH){rd_coef[DATA_WIDTH-1]}}, rd_coef};

  // A write can only target an EMPTY bank and a read only a FULL one, so the two never collide.
  always_comb begin
    bank_nxt[0] = bank_st[0];
    bank_nxt[1] = bank_st[1];
    if (wr_close) bank_nxt[wr_bank] = FULL;
    if (rd_close) bank_nxt[rd_bank] = EMPTY;
    rd_bank_nxt = rd_bank ^ rd_close;
    rd_idx_nxt  = rd_close ? 6'd0 : rd_idx + {5'd0, rd_fire};
  end

  always_ff @(posedge axis_aclk) begin
    if (wr_fire)
      mem[wr_bank][wr_addr] <= s00_axis_tdata[DATA_WIDTH-1:0];
  end

  // Read state looks ahead at next-cycle bank state so a just-filled bank streams one cycle later.
  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      bank_st[0]     <= EMPTY;
      bank_st[1]     <= EMPTY;
      wr_bank        <= 1'b0;
      rd_bank        <= 1'b0;
      wr_idx         <= 6'd0;
      rd_idx         <= 6'd0;
      rd_state       <= IDLE;
      m00_axis_tlast <= 1'b0;
    end else begin
      bank_st[0] <= bank_nxt[0];
      bank_st[1] <= bank_nxt[1];
      if (wr_fire)
        wr_idx <= wr_close ? 6'd0 : wr_idx + 6'd1;
      if (wr_close)
        wr_bank <= ~wr_bank;
      rd_bank <= rd_bank_nxt;
      rd_idx  <= rd_idx_nxt;
      if (bank_nxt[rd_bank_nxt] == FULL) begin
        rd_state       <= STREAM;
        m00_axis_tlast <= (rd_idx_nxt == LAST_IDX);
      end else begin
        rd_state       <= IDLE;
        m00_axis_tlast <= 1'b0;
      end
    end
  end

endmodule
